// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared types and constants for the posted-write buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    // Request direction encoding on both S_rw and M_rw
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Default widths of a queued entry
    localparam int unsigned c_ADDR_W = 32;
    localparam int unsigned c_DATA_W = 32;

    // One queued posted write at the default widths
    typedef struct packed {
        logic [c_ADDR_W-1:0] addr;
        logic [c_DATA_W-1:0] data;
    } wb_entry_t;

    // Cache-facing request handler
    typedef enum logic [1:0] {
        U_IDLE      = 2'd0,
        U_WAIT_SLOT = 2'd1,
        U_RD_MEM    = 2'd2,
        U_RESP      = 2'd3
    } u_state_e;

    // Memory-facing transaction issuer
    typedef enum logic [1:0] {
        D_IDLE  = 2'd0,
        D_DRAIN = 2'd1,
        D_READ  = 2'd2
    } d_state_e;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Circular store of {address, data} posted writes with
//               full/empty flags and a youngest-match address search.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [ADDR_W-1:0] o_head_addr,
    output logic [DATA_W-1:0] o_head_data,
    input  logic [ADDR_W-1:0] i_search_addr,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_hit_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int unsigned c_IDX_W = $clog2(DEPTH);
    localparam int unsigned c_PTR_W = c_IDX_W + 1;

    logic [ADDR_W-1:0]  r_addr [DEPTH];
    logic [DATA_W-1:0]  r_data [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] w_count;
    logic               w_do_push;
    logic               w_do_pop;

    // The extra pointer MSB distinguishes full from empty when indices match
    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_PTR_W-1] != r_rd_ptr[c_PTR_W-1]) &&
                       (r_wr_ptr[c_IDX_W-1:0] == r_rd_ptr[c_IDX_W-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    assign o_head_addr = r_addr[r_rd_ptr[c_IDX_W-1:0]];
    assign o_head_data = r_data[r_rd_ptr[c_IDX_W-1:0]];

    // Pointer update; a simultaneous push and pop advances both
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Entry storage; contents need no reset because the pointers gate validity
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_addr[r_wr_ptr[c_IDX_W-1:0]] <= i_addr;
            r_data[r_wr_ptr[c_IDX_W-1:0]] <= i_data;
        end
    end

    // Walk oldest to youngest over valid entries so the youngest match wins
    always_comb begin
        o_hit      = 1'b0;
        o_hit_data = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            logic [c_IDX_W-1:0] w_slot;
            w_slot = r_rd_ptr[c_IDX_W-1:0] + c_IDX_W'(i);
            if ((c_PTR_W'(i) < w_count) && (r_addr[w_slot] == i_search_addr)) begin
                o_hit      = 1'b1;
                o_hit_data = r_data[w_slot];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : write_buffer
// Description : Posted-write buffer between the cache system port and main
//               memory. Stores are queued and drained in the background;
//               reads are served from the buffer on a hit or bypass the
//               queued writes to memory on a miss.
// Revision    : 1.0 - initial release
// ============================================================================
module write_buffer
    import wb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              S_strobe,
    input  logic              S_rw,
    input  logic [ADDR_W-1:0] S_address,
    input  logic [DATA_W-1:0] S_data_out,
    output logic [DATA_W-1:0] S_data_in,
    output logic              S_ready,
    output logic              M_strobe,
    output logic              M_rw,
    output logic [ADDR_W-1:0] M_address,
    output logic [DATA_W-1:0] M_data_out,
    input  logic [DATA_W-1:0] M_data_in,
    input  logic              M_ready,
    output logic              wb_empty,
    output logic              wb_full
);

    u_state_e          r_u_state;
    u_state_e          w_u_next;
    d_state_e          r_d_state;
    d_state_e          w_d_next;

    logic              w_push;
    logic              w_pop;
    logic              w_load_hit;
    logic              w_load_miss;
    logic              w_load_mem;
    logic              w_issue_read;
    logic              w_issue_drain;

    logic              w_full;
    logic              w_empty;
    logic              w_hit;
    logic [DATA_W-1:0] w_hit_data;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;

    logic [ADDR_W-1:0] r_rd_addr;
    logic [DATA_W-1:0] r_s_data_in;
    logic              r_m_strobe;
    logic              r_m_rw;
    logic [ADDR_W-1:0] r_m_address;
    logic [DATA_W-1:0] r_m_data_out;

    wb_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .i_push        (w_push),
        .i_addr        (S_address),
        .i_data        (S_data_out),
        .i_pop         (w_pop),
        .o_head_addr   (w_head_addr),
        .o_head_data   (w_head_data),
        .i_search_addr (S_address),
        .o_hit         (w_hit),
        .o_hit_data    (w_hit_data),
        .o_full        (w_full),
        .o_empty       (w_empty)
    );

    // Upstream next-state: accept writes into the queue, answer reads
    always_comb begin
        w_u_next    = r_u_state;
        w_push      = 1'b0;
        w_load_hit  = 1'b0;
        w_load_miss = 1'b0;
        w_load_mem  = 1'b0;
        case (r_u_state)
            U_IDLE: begin
                if (S_strobe) begin
                    if (S_rw == RW_WRITE) begin
                        if (!w_full) begin
                            w_push   = 1'b1;
                            w_u_next = U_RESP;
                        end else begin
                            w_u_next = U_WAIT_SLOT;
                        end
                    end else if (w_hit) begin
                        w_load_hit = 1'b1;
                        w_u_next   = U_RESP;
                    end else begin
                        w_load_miss = 1'b1;
                        w_u_next    = U_RD_MEM;
                    end
                end
            end
            U_WAIT_SLOT: begin
                // Registered full only: a pop this cycle frees the slot next cycle
                if (!w_full) begin
                    w_push   = 1'b1;
                    w_u_next = U_RESP;
                end
            end
            U_RD_MEM: begin
                if ((r_d_state == D_READ) && M_ready) begin
                    w_load_mem = 1'b1;
                    w_u_next   = U_RESP;
                end
            end
            U_RESP:  w_u_next = U_IDLE;
            default: w_u_next = U_IDLE;
        endcase
    end

    // Upstream state, read-data capture and latched miss address
    always_ff @(posedge clk) begin
        if (rst) begin
            r_u_state   <= U_IDLE;
            r_s_data_in <= '0;
            r_rd_addr   <= '0;
        end else begin
            r_u_state <= w_u_next;
            if (w_load_hit)  r_s_data_in <= w_hit_data;
            if (w_load_mem)  r_s_data_in <= M_data_in;
            if (w_load_miss) r_rd_addr   <= S_address;
        end
    end

    // Downstream next-state: a pending read miss beats draining the queue
    always_comb begin
        w_d_next      = r_d_state;
        w_pop         = 1'b0;
        w_issue_read  = 1'b0;
        w_issue_drain = 1'b0;
        case (r_d_state)
            D_IDLE: begin
                if (r_u_state == U_RD_MEM) begin
                    w_issue_read = 1'b1;
                    w_d_next     = D_READ;
                end else if (!w_empty) begin
                    w_issue_drain = 1'b1;
                    w_d_next      = D_DRAIN;
                end
            end
            D_DRAIN: begin
                if (M_ready) begin
                    w_pop    = 1'b1;
                    w_d_next = D_IDLE;
                end
            end
            D_READ: begin
                if (M_ready) w_d_next = D_IDLE;
            end
            default: w_d_next = D_IDLE;
        endcase
    end

    // Downstream state and registered memory request, held until M_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d_state    <= D_IDLE;
            r_m_strobe   <= 1'b0;
            r_m_rw       <= RW_READ;
            r_m_address  <= '0;
            r_m_data_out <= '0;
        end else begin
            r_d_state <= w_d_next;
            if (w_issue_read) begin
                r_m_strobe   <= 1'b1;
                r_m_rw       <= RW_READ;
                r_m_address  <= r_rd_addr;
                r_m_data_out <= '0;
            end else if (w_issue_drain) begin
                r_m_strobe   <= 1'b1;
                r_m_rw       <= RW_WRITE;
                r_m_address  <= w_head_addr;
                r_m_data_out <= w_head_data;
            end else if ((r_d_state != D_IDLE) && M_ready) begin
                r_m_strobe <= 1'b0;
            end
        end
    end

    assign S_ready    = (r_u_state == U_RESP);
    assign S_data_in  = r_s_data_in;
    assign M_strobe   = r_m_strobe;
    assign M_rw       = r_m_rw;
    assign M_address  = r_m_address;
    assign M_data_out = r_m_data_out;
    assign wb_empty   = w_empty;
    assign wb_full    = w_full;

endmodule
`default_nettype wire

// File: tb/tb_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_write_buffer
// Description : Directed self-checking bench for write_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_write_buffer;
    import wb_pkg::*;

    logic        clk;
    logic        rst;
    logic        S_strobe;
    logic        S_rw;
    logic [31:0] S_address;
    logic [31:0] S_data_out;
    logic [31:0] S_data_in;
    logic        S_ready;
    logic        M_strobe;
    logic        M_rw;
    logic [31:0] M_address;
    logic [31:0] M_data_out;
    logic [31:0] M_data_in;
    logic        M_ready;
    logic        wb_empty;
    logic        wb_full;

    // Memory responder controls
    logic        m_mode;   // 0: M_ready = m_level, 1: random pulse while M_strobe
    logic        m_level;
    logic        r_rand;

    int checks;
    int errors;

    typedef struct packed {
        logic      rw;
        wb_entry_t e;
    } log_t;
    log_t mem_log[$];

    write_buffer #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .S_strobe   (S_strobe),
        .S_rw       (S_rw),
        .S_address  (S_address),
        .S_data_out (S_data_out),
        .S_data_in  (S_data_in),
        .S_ready    (S_ready),
        .M_strobe   (M_strobe),
        .M_rw       (M_rw),
        .M_address  (M_address),
        .M_data_out (M_data_out),
        .M_data_in  (M_data_in),
        .M_ready    (M_ready),
        .wb_empty   (wb_empty),
        .wb_full    (wb_full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Random completion source for the wrap scenario
    always @(negedge clk) r_rand <= 1'($urandom_range(0, 1));

    always_comb M_ready = m_mode ? (M_strobe && r_rand) : m_level;

    // Record every completed memory transaction
    always @(posedge clk) begin
        if (!rst && M_strobe && M_ready)
            mem_log.push_back({M_rw, M_address, M_data_out});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Raise a write one negedge later and wait for S_ready; lat = -1 on timeout
    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input int limit, output int lat);
        @(negedge clk);
        S_strobe = 1'b1; S_rw = RW_WRITE; S_address = a; S_data_out = d;
        lat = -1;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (S_ready === 1'b1) begin lat = c; break; end
        end
        S_strobe = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input int limit,
                           output int lat, output logic [31:0] d);
        @(negedge clk);
        S_strobe = 1'b1; S_rw = RW_READ; S_address = a;
        lat = -1;
        d   = '0;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (S_ready === 1'b1) begin lat = c; d = S_data_in; break; end
        end
        S_strobe = 1'b0;
    endtask

    task automatic wait_empty(input int limit, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (wb_empty === 1'b1 && M_strobe === 1'b0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({S_ready, S_data_in, M_strobe, M_rw} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_s_m: got rdy=%0b din=%h mstb=%0b mrw=%0b exp 0 0 0 1",
                     S_ready, S_data_in, M_strobe, M_rw);
        end
        checks++;
        if ({M_address, M_data_out, wb_empty, wb_full} !== {32'h0, 32'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_addr_flags: got a=%h d=%h e=%0b f=%0b exp 0 0 1 0",
                     M_address, M_data_out, wb_empty, wb_full);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_write;
        m_mode = 1'b0; m_level = 1'b1;
        mem_log.delete();
        @(negedge clk);
        S_strobe = 1'b1; S_rw = RW_WRITE; S_address = 32'h100; S_data_out = 32'hA5A5A5A5;
        @(negedge clk);
        checks++;
        if ({S_ready, M_strobe, wb_empty} !== 3'b100) begin
            errors++;
            $display("FAIL single_ready: got rdy=%0b mstb=%0b empty=%0b exp 1 0 0",
                     S_ready, M_strobe, wb_empty);
        end
        S_strobe = 1'b0;
        @(negedge clk);
        checks++;
        if ({S_ready, M_strobe, M_rw, M_address, M_data_out} !==
            {1'b0, 1'b1, 1'b0, 32'h100, 32'hA5A5A5A5}) begin
            errors++;
            $display("FAIL single_mreq: got rdy=%0b stb=%0b rw=%0b a=%h d=%h exp 0 1 0 100 a5a5a5a5",
                     S_ready, M_strobe, M_rw, M_address, M_data_out);
        end
        @(negedge clk);
        checks++;
        if ({wb_empty, M_strobe} !== 2'b10 || mem_log.size() != 1) begin
            errors++;
            $display("FAIL single_drained: got empty=%0b stb=%0b log=%0d exp 1 0 1",
                     wb_empty, M_strobe, mem_log.size());
        end
    endtask

    task automatic test_full_stall;
        int          lat;
        logic        bad;
        logic        ok;
        logic [31:0] a;
        m_mode = 1'b0; m_level = 1'b0;
        mem_log.delete();
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 32'(i * 4);
            do_write(a, 32'hD000_0000 | a, 10, lat);
            if (lat != 1) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0 || wb_full !== 1'b1) begin
            errors++;
            $display("FAIL fill_four: got latbad=%0b full=%0b exp 0 1", bad, wb_full);
        end
        @(negedge clk);
        S_strobe = 1'b1; S_rw = RW_WRITE; S_address = 32'h10; S_data_out = 32'hD000_0010;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (S_ready !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0 || wb_full !== 1'b1) begin
            errors++;
            $display("FAIL fifth_held: got sawready=%0b full=%0b exp 0 1", bad, wb_full);
        end
        m_level = 1'b1;
        @(negedge clk);
        m_level = 1'b0;
        checks++;
        if ({S_ready, wb_full} !== 2'b00) begin
            errors++;
            $display("FAIL fifth_after_pop: got rdy=%0b full=%0b exp 0 0", S_ready, wb_full);
        end
        @(negedge clk);
        checks++;
        if ({S_ready, wb_full} !== 2'b11) begin
            errors++;
            $display("FAIL fifth_ready: got rdy=%0b full=%0b exp 1 1", S_ready, wb_full);
        end
        S_strobe = 1'b0;
        m_level = 1'b1;
        wait_empty(50, ok);
        bad = !ok || (mem_log.size() != 5);
        for (int i = 0; i < 5 && i < mem_log.size(); i++) begin
            a = 32'(i * 4);
            if (mem_log[i] !== {RW_WRITE, a, 32'hD000_0000 | a}) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL fill_order: got drained=%0b log=%0d exp 1 5 in order", ok, mem_log.size());
        end
    endtask

    task automatic test_read_hit;
        int          lat;
        logic [31:0] d;
        logic        ok;
        m_mode = 1'b0; m_level = 1'b0;
        mem_log.delete();
        do_write(32'h40, 32'h1, 10, lat);
        do_write(32'h40, 32'h2, 10, lat);
        do_read(32'h40, 10, lat, d);
        checks++;
        if (lat != 1 || d !== 32'h2) begin
            errors++;
            $display("FAIL hit_youngest: got lat=%0d data=%h exp 1 2", lat, d);
        end
        checks++;
        if ({M_strobe, M_rw} !== 2'b10 || mem_log.size() != 0) begin
            errors++;
            $display("FAIL hit_no_mread: got stb=%0b rw=%0b log=%0d exp 1 0 0",
                     M_strobe, M_rw, mem_log.size());
        end
        m_level = 1'b1;
        wait_empty(50, ok);
        checks++;
        if (!ok || mem_log.size() != 2 ||
            mem_log[0] !== {RW_WRITE, 32'h40, 32'h1} ||
            mem_log[1] !== {RW_WRITE, 32'h40, 32'h2}) begin
            errors++;
            $display("FAIL hit_drain: got drained=%0b log=%0d exp 1 2 writes", ok, mem_log.size());
        end
    endtask

    task automatic test_read_miss;
        int   lat;
        logic bad;
        logic ok;
        m_mode = 1'b0; m_level = 1'b0;
        M_data_in = 32'hDEAD;
        mem_log.delete();
        do_write(32'h40, 32'h11, 10, lat);
        do_write(32'h44, 32'h22, 10, lat);
        @(negedge clk);
        S_strobe = 1'b1; S_rw = RW_READ; S_address = 32'h80;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (S_ready !== 1'b0 || M_rw !== RW_WRITE || M_address !== 32'h40) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL miss_waits_drain: got rdy=%0b rw=%0b a=%h exp 0 0 40",
                     S_ready, M_rw, M_address);
        end
        m_level = 1'b1;
        @(negedge clk);
        m_level = 1'b0;
        @(negedge clk);
        checks++;
        if ({M_strobe, M_rw, M_address, S_ready} !== {1'b1, 1'b1, 32'h80, 1'b0}) begin
            errors++;
            $display("FAIL miss_mread: got stb=%0b rw=%0b a=%h rdy=%0b exp 1 1 80 0",
                     M_strobe, M_rw, M_address, S_ready);
        end
        m_level = 1'b1;
        @(negedge clk);
        checks++;
        if ({S_ready, S_data_in} !== {1'b1, 32'hDEAD}) begin
            errors++;
            $display("FAIL miss_data: got rdy=%0b data=%h exp 1 dead", S_ready, S_data_in);
        end
        S_strobe = 1'b0;
        wait_empty(50, ok);
        checks++;
        if (!ok || mem_log.size() != 3 ||
            mem_log[0] !== {RW_WRITE, 32'h40, 32'h11} ||
            {mem_log[1].rw, mem_log[1].e.addr} !== {RW_READ, 32'h80} ||
            mem_log[2] !== {RW_WRITE, 32'h44, 32'h22}) begin
            errors++;
            $display("FAIL miss_order: got drained=%0b log=%0d exp 1 3 (W40 R80 W44)",
                     ok, mem_log.size());
        end
    endtask

    task automatic test_wrap_random;
        int          lat;
        logic        ok;
        logic        bad;
        logic [31:0] a;
        m_mode = 1'b1;
        mem_log.delete();
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            do_write(32'h200 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 100, lat);
            if (lat < 0) bad = 1'b1;
        end
        wait_empty(500, ok);
        m_mode = 1'b0;
        checks++;
        if (bad !== 1'b0 || !ok || mem_log.size() != 8) begin
            errors++;
            $display("FAIL wrap_count: got timeout=%0b drained=%0b log=%0d exp 0 1 8",
                     bad, ok, mem_log.size());
        end
        for (int i = 0; i < 8 && i < mem_log.size(); i++) begin
            a = 32'h200 + 32'(i * 4);
            checks++;
            if (mem_log[i] !== {RW_WRITE, a, 32'hC0DE_0000 + 32'(i)}) begin
                errors++;
                $display("FAIL wrap_entry%0d: got rw=%0b a=%h d=%h exp 0 %h %h", i,
                         mem_log[i].rw, mem_log[i].e.addr, mem_log[i].e.data,
                         a, 32'hC0DE_0000 + 32'(i));
            end
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        m_mode = 1'b0; m_level = 1'b0;
        do_write(32'h300, 32'h3, 10, lat);
        do_write(32'h304, 32'h4, 10, lat);
        checks++;
        if ({M_strobe, wb_empty} !== 2'b10) begin
            errors++;
            $display("FAIL rstmid_pre: got stb=%0b empty=%0b exp 1 0", M_strobe, wb_empty);
        end
        mem_log.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({M_strobe, wb_empty, S_ready, wb_full} !== 4'b0100) begin
            errors++;
            $display("FAIL rstmid_post: got stb=%0b empty=%0b rdy=%0b full=%0b exp 0 1 0 0",
                     M_strobe, wb_empty, S_ready, wb_full);
        end
        rst = 1'b0;
        m_level = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (mem_log.size() != 0 || M_strobe !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_discard: got log=%0d stb=%0b exp 0 0", mem_log.size(), M_strobe);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1;
        S_strobe = 1'b0; S_rw = RW_READ; S_address = '0; S_data_out = '0;
        M_data_in = '0;
        m_mode = 1'b0; m_level = 1'b0;
        test_reset();
        test_single_write();
        test_full_stall();
        test_read_hit();
        test_read_miss();
        test_wrap_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/write_buffer.md
Name: write_buffer

Overview:
- Posted-write buffer between the cache's system-side port (`S_*`) and main memory (`M_*`).
- Write-through stores from the cache are queued in a FIFO and retired to memory in the background, so the cache no longer stalls for every store.
- Reads check the buffer first: a hit returns the youngest matching write, a miss is forwarded to memory.
- Reads may bypass queued writes because a miss guarantees no address conflict.

Parameters:
- ADDR_W, 32, byte address width of S_address / M_address.
- DATA_W, 32, data word width.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- S_strobe  in  1  request from cache; held until S_ready.
- S_rw  in  1  1 = read, 0 = write; stable while S_strobe is high.
- S_address  in  ADDR_W  request address.
- S_data_out  in  DATA_W  write data from cache.
- S_data_in  out  DATA_W  read data to cache; registered.
- S_ready  out  1  one-cycle completion pulse.
- M_strobe  out  1  memory request; held until M_ready.
- M_rw  out  1  1 = read, 0 = write.
- M_address  out  ADDR_W  memory address.
- M_data_out  out  DATA_W  memory write data.
- M_data_in  in  DATA_W  memory read data; valid when M_ready = 1.
- M_ready  in  1  memory completion; one cycle.
- wb_empty  out  1  no entries queued.
- wb_full  out  1  count == DEPTH.

Behaviour:
- Reset (sync, rst = 1 at a clk edge):
  - Clears count and pointers; all queued writes are discarded.
  - Both FSMs go to idle.
  - S_ready = 0, S_data_in = 0, M_strobe = 0, M_rw = 1, M_address = 0, M_data_out = 0, wb_empty = 1, wb_full = 0.
  - Reset asserted mid-transaction drops M_strobe on the next edge; no S_ready is issued for the aborted request.
- Storage:
  - Circular FIFO of {address, data}.
  - Pointers are log2(DEPTH)+1 bits; the extra MSB is the wrap bit.
  - full = (ptr MSBs differ && low bits equal); empty = (pointers equal).
- Upstream FSM, states U_IDLE, U_WAIT_SLOT, U_RD_MEM, U_RESP:
  - U_IDLE, write, not full: enqueue at edge N; S_ready = 1 in cycle N+1 (U_RESP).
  - U_IDLE, write, full: go to U_WAIT_SLOT. Enqueue on the first edge where registered full = 0. A pop in the same cycle does not free a slot for that cycle's enqueue.
  - U_IDLE, read: compare S_address against all valid entries, including the head currently being drained.
    - Hit: youngest match wins. S_data_in <= entry data; S_ready in N+1.
    - Miss: go to U_RD_MEM and raise a read request to the downstream FSM.
  - U_RD_MEM: on the M_ready cycle K of the read, S_data_in <= M_data_in; S_ready in K+1.
  - U_RESP → U_IDLE. The requester drops S_strobe after S_ready, so no re-accept occurs.
- Downstream FSM, states D_IDLE, D_DRAIN, D_READ:
  - D_IDLE + pending read: D_READ. The read takes priority over draining.
  - Otherwise, D_IDLE + non-empty: D_DRAIN with the head entry, M_rw = 0.
  - M_strobe, M_rw, M_address and M_data_out are registered and stable until M_ready.
  - D_DRAIN, M_ready: pop head, then D_IDLE.
  - D_READ, M_ready: capture data, then D_IDLE.
  - A read that arrives during a drain waits for that drain's M_ready, then issues from the following cycle.
  - At most one memory transaction is outstanding.
- Simultaneous enqueue and pop in one cycle: count unchanged, both pointers advance.
- Pointer wrap at DEPTH is exercised by the normal modulo arithmetic.

Decomposition:
- Package wb_pkg:
  - RW_READ = 1'b1, RW_WRITE = 1'b0.
  - typedef wb_entry_t {addr, data}.
  - Upstream and downstream state enums.
- Sub-module wb_fifo: storage, pointers, full/empty, and the youngest-match search. It outputs hit and hit_data.
- The two FSMs live in write_buffer.

Test Plan:
- Reset then single write, addr 0x100, data 0xA5A5A5A5, M_ready tied high:
  - S_ready one cycle after strobe.
  - M_strobe next cycle with M_rw = 0, 0x100, 0xA5A5A5A5.
  - wb_empty = 1 after the pop.
- Four writes (0x0, 0x4, 0x8, 0xC) with M_ready held low:
  - wb_full = 1 and S_ready returned for all four.
  - A fifth write (0x10) is held with no S_ready.
  - Pulse M_ready: 0x0 pops, 0x10 enqueues next cycle, S_ready the cycle after.
- Writes 0x40 = 1 then 0x40 = 2 queued, then read 0x40 → S_data_in = 2, S_ready one cycle after strobe, no M read issued.
- Read miss 0x80 while the buffer holds 0x40 and a drain is in flight, M_data_in = 0xDEAD:
  - M read issues after the drain's M_ready, before remaining writes.
  - S_data_in = 0xDEAD, one cycle after the read's M_ready.
- Write eight entries through DEPTH = 4 with random M_ready:
  - The memory sees all eight in order.
  - The pointers wrap with no lost or duplicated entry.
- Assert rst while M_strobe = 1 and two entries are queued:
  - Next cycle M_strobe = 0, wb_empty = 1, S_ready = 0.
  - The discarded entries are never written to memory.
